// File: rtl/tempsens_scan_ctrl.sv
// Scan controller for delay-line temperature sensors: sweeps or SAR-searches a shared
// DAC code per masked channel, averages 2**N_AVG_LOG2 conversions, and hands results out.
module tempsens_scan_ctrl #(
    parameter int N_VDAC     = 7,
    parameter int N_CH       = 2,
    parameter int N_AVG_LOG2 = 2,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [N_CH-1:0]   i_ch_mask,
    input  logic [N_CH-1:0]   i_tempdelay,
    output logic [N_VDAC-1:0] o_dac_data,
    output logic [N_CH-1:0]   o_dac_en,
    output logic              o_precharge_n,
    output logic              o_busy,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [N_VDAC-1:0] o_result,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_nodetect
);

    localparam int ACC_W = N_VDAC + N_AVG_LOG2;
    localparam logic [N_VDAC-1:0] VMAX = '1;
    localparam logic [N_VDAC-1:0] VMIN = '0;
    localparam logic [N_AVG_LOG2:0] CONV_LAST = (N_AVG_LOG2 + 1)'((1 << N_AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_TRANSITION,
        S_MEASURE,
        S_EVALUATE,
        S_OUTPUT
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [N_CH-1:0]     pending_q, pending_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [N_VDAC-1:0]   trial_q, trial_d;
    logic                prev_hit_q, prev_hit_d;
    logic [N_VDAC-1:0]   code_q, code_d;
    logic [N_VDAC-1:0]   bit_q, bit_d;
    logic                any_hit_q, any_hit_d;
    logic [N_AVG_LOG2:0] conv_q, conv_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                nd_acc_q, nd_acc_d;
    logic [N_VDAC-1:0]   result_q, result_d;
    logic                nodetect_q, nodetect_d;

    logic                hit;
    logic                start_channel;
    logic                init_conv;
    logic                conv_done;
    logic [N_VDAC-1:0]   conv_code;
    logic                conv_nd;
    logic [N_VDAC-1:0]   sar_code;
    logic [ACC_W-1:0]    acc_sum;
    logic                nd_sum;
    logic [N_VDAC-1:0]   trial_dac;

    function automatic logic [CH_W-1:0] first_set(input logic [N_CH-1:0] m);
        logic [CH_W-1:0] idx;
        logic            found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (m[i] && !found) begin
                idx   = CH_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [N_CH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            v[i] = (idx == CH_W'(i));
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            pending_q  <= '0;
            ch_q       <= '0;
            trial_q    <= VMAX;
            prev_hit_q <= 1'b1;
            code_q     <= '0;
            bit_q      <= '0;
            any_hit_q  <= 1'b0;
            conv_q     <= '0;
            acc_q      <= '0;
            nd_acc_q   <= 1'b0;
            result_q   <= '0;
            nodetect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pending_q  <= pending_d;
            ch_q       <= ch_d;
            trial_q    <= trial_d;
            prev_hit_q <= prev_hit_d;
            code_q     <= code_d;
            bit_q      <= bit_d;
            any_hit_q  <= any_hit_d;
            conv_q     <= conv_d;
            acc_q      <= acc_d;
            nd_acc_q   <= nd_acc_d;
            result_q   <= result_d;
            nodetect_q <= nodetect_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        pending_d     = pending_q;
        ch_d          = ch_q;
        trial_d       = trial_q;
        prev_hit_d    = prev_hit_q;
        code_d        = code_q;
        bit_d         = bit_q;
        any_hit_d     = any_hit_q;
        conv_d        = conv_q;
        acc_d         = acc_q;
        nd_acc_d      = nd_acc_q;
        result_d      = result_q;
        nodetect_d    = nodetect_q;
        start_channel = 1'b0;
        init_conv     = 1'b0;
        conv_done     = 1'b0;
        conv_code     = '0;
        conv_nd       = 1'b0;
        hit           = i_tempdelay[ch_q];
        sar_code      = hit ? (code_q | bit_q) : code_q;
        acc_sum       = '0;
        nd_sum        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start && (|i_ch_mask)) begin
                    mode_d        = i_mode;
                    ch_d          = first_set(i_ch_mask);
                    pending_d     = i_ch_mask & ~onehot(ch_d);
                    start_channel = 1'b1;
                    state_d       = S_PRECHARGE;
                end
            end
            S_PRECHARGE:  state_d = S_TRANSITION;
            S_TRANSITION: state_d = S_MEASURE;
            S_MEASURE:    state_d = S_EVALUATE;
            S_EVALUATE: begin
                state_d = S_PRECHARGE;
                if (!mode_q) begin
                    // Linear sweep ends on the first miss-to-hit edge while stepping down.
                    if (!prev_hit_q && hit) begin
                        conv_done = 1'b1;
                        conv_code = trial_q;
                    end else if (trial_q == VMIN) begin
                        conv_done = 1'b1;
                        conv_nd   = 1'b1;
                    end else begin
                        trial_d    = trial_q - 1'b1;
                        prev_hit_d = hit;
                    end
                end else begin
                    if (bit_q[0]) begin
                        conv_done = 1'b1;
                        conv_code = sar_code;
                        conv_nd   = !(any_hit_q || hit);
                    end else begin
                        code_d    = sar_code;
                        bit_d     = bit_q >> 1;
                        any_hit_d = any_hit_q || hit;
                    end
                end
                if (conv_done) begin
                    acc_sum = acc_q + ACC_W'(conv_code);
                    nd_sum  = nd_acc_q || conv_nd;
                    if (conv_q == CONV_LAST) begin
                        result_d   = acc_sum[ACC_W-1 -: N_VDAC];
                        nodetect_d = nd_sum;
                        state_d    = S_OUTPUT;
                    end else begin
                        acc_d     = acc_sum;
                        nd_acc_d  = nd_sum;
                        conv_d    = conv_q + 1'b1;
                        init_conv = 1'b1;
                    end
                end
            end
            S_OUTPUT: begin
                if (i_ready) begin
                    if (|pending_q) begin
                        ch_d          = first_set(pending_q);
                        pending_d     = pending_q & ~onehot(ch_d);
                        start_channel = 1'b1;
                        state_d       = S_PRECHARGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_channel) begin
            acc_d     = '0;
            nd_acc_d  = 1'b0;
            conv_d    = '0;
            init_conv = 1'b1;
        end
        if (init_conv) begin
            trial_d           = VMAX;
            prev_hit_d        = 1'b1;
            code_d            = '0;
            bit_d             = '0;
            bit_d[N_VDAC-1]   = 1'b1;
            any_hit_d         = 1'b0;
        end
    end

    always_comb begin
        trial_dac     = mode_q ? (code_q | bit_q) : trial_q;
        o_dac_data    = VMAX;
        o_dac_en      = '0;
        o_precharge_n = 1'b0;
        o_busy        = (state_q != S_IDLE);
        o_valid       = (state_q == S_OUTPUT);
        case (state_q)
            S_PRECHARGE: begin
                o_dac_en = onehot(ch_q);
            end
            S_TRANSITION: begin
                o_dac_data    = VMIN;
                o_dac_en      = onehot(ch_q);
                o_precharge_n = 1'b1;
            end
            S_MEASURE, S_EVALUATE: begin
                o_dac_data    = trial_dac;
                o_dac_en      = onehot(ch_q);
                o_precharge_n = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_result   = result_q;
    assign o_ch       = ch_q;
    assign o_nodetect = nodetect_q;

endmodule

// File: tb/tb_tempsens_scan_ctrl.sv
// Bench for tempsens_scan_ctrl: threshold sensor model (hit = dac <= T) and a
// scoreboard of expected {ch, result, nodetect} per channel result.
module tb_tempsens_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic       i_mode;
    logic [1:0] i_ch_mask;
    logic [1:0] i_tempdelay;
    logic [6:0] o_dac_data;
    logic [1:0] o_dac_en;
    logic       o_precharge_n;
    logic       o_busy;
    logic       o_valid;
    logic       i_ready;
    logic [6:0] o_result;
    logic [0:0] o_ch;
    logic       o_nodetect;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];
    logic [8:0] exp_v;

    int  t_val[2];
    int  sweep_seq[4] = '{40, 41, 42, 43};
    bit  sweep_en  = 0;
    bit  stuck_en  = 0;
    bit  stuck_val = 0;
    bit  pc_clr    = 0;
    int  pc_cnt    = 0;

    tempsens_scan_ctrl #(
        .N_VDAC     (7),
        .N_CH       (2),
        .N_AVG_LOG2 (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_mode        (i_mode),
        .i_ch_mask     (i_ch_mask),
        .i_tempdelay   (i_tempdelay),
        .o_dac_data    (o_dac_data),
        .o_dac_en      (o_dac_en),
        .o_precharge_n (o_precharge_n),
        .o_busy        (o_busy),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result      (o_result),
        .o_ch          (o_ch),
        .o_nodetect    (o_nodetect)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (pc_clr) pc_cnt <= 0;
        else if (!o_precharge_n && o_dac_en[0]) pc_cnt <= pc_cnt + 1;
    end

    // Sweep mode moves channel 0's threshold every 7 SAR trials (one conversion).
    always_comb begin
        int idx;
        int t0;
        idx = (pc_cnt > 0) ? (pc_cnt - 1) / 7 : 0;
        if (idx > 3) idx = 3;
        t0 = sweep_en ? sweep_seq[idx] : t_val[0];
        i_tempdelay[0] = stuck_en ? stuck_val : (int'(o_dac_data) <= t0);
        i_tempdelay[1] = stuck_en ? stuck_val : (int'(o_dac_data) <= t_val[1]);
    end

    task automatic do_start(input bit mode, input logic [1:0] mask);
        @(negedge clk);
        i_mode    = mode;
        i_ch_mask = mask;
        i_start   = 1;
        @(negedge clk);
        i_start   = 0;
    endtask

    task automatic wait_valid(input int max, output bit ok, output int active);
        active = 0;
        for (int i = 0; i < max && !o_valid; i++) begin
            if (o_dac_en != 2'b00) active++;
            @(negedge clk);
        end
        ok = o_valid;
    endtask

    task automatic test_reset;
        reset = 1; i_start = 0; i_mode = 0; i_ch_mask = 0; i_ready = 1;
        t_val[0] = 0; t_val[1] = 0;
        #1;
        checks++; if (o_dac_data !== 7'h7f) begin errors++; $display("FAIL reset_dac: got %0h expected 7f", o_dac_data); end
        checks++; if (o_dac_en !== 2'b00) begin errors++; $display("FAIL reset_en: got %b expected 00", o_dac_en); end
        checks++; if ({o_precharge_n, o_busy, o_valid} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", {o_precharge_n, o_busy, o_valid}); end
        checks++; if ({o_ch, o_result, o_nodetect} !== 9'h0) begin errors++; $display("FAIL reset_res: got %0h expected 0", {o_ch, o_result, o_nodetect}); end
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_mask_zero;
        do_start(0, 2'b00);
        repeat (3) begin
            checks++;
            if ({o_busy, o_valid, o_dac_en, o_precharge_n} !== 5'b0) begin
                errors++; $display("FAIL mask_zero: got %b expected 00000", {o_busy, o_valid, o_dac_en, o_precharge_n});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_linear;
        bit ok;
        int cnt;
        t_val[0] = 50;
        sb.push_back({1'b0, 7'd50, 1'b0});
        do_start(0, 2'b01);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL lin_busy: got %b expected 1", o_busy); end
        checks++; if ({o_dac_data, o_precharge_n, o_dac_en} !== {7'h7f, 1'b0, 2'b01}) begin errors++; $display("FAIL lin_precharge: got %0h expected %0h", {o_dac_data, o_precharge_n, o_dac_en}, {7'h7f, 1'b0, 2'b01}); end
        @(negedge clk);
        checks++; if ({o_dac_data, o_precharge_n} !== {7'h00, 1'b1}) begin errors++; $display("FAIL lin_transition: got %0h expected %0h", {o_dac_data, o_precharge_n}, {7'h00, 1'b1}); end
        @(negedge clk);
        checks++; if ({o_dac_data, o_precharge_n} !== {7'h7f, 1'b1}) begin errors++; $display("FAIL lin_measure: got %0h expected %0h", {o_dac_data, o_precharge_n}, {7'h7f, 1'b1}); end
        wait_valid(3000, ok, cnt);
        cnt += 2;
        checks++; if (!ok) begin errors++; $display("FAIL lin_timeout: got valid=0 expected valid=1"); end
        checks++; if (cnt !== 1248) begin errors++; $display("FAIL lin_cycles: got %0d expected 1248", cnt); end
        checks++; if ({o_dac_data, o_precharge_n, o_dac_en, o_busy} !== {7'h7f, 1'b0, 2'b00, 1'b1}) begin errors++; $display("FAIL lin_output_pins: got %0h expected %0h", {o_dac_data, o_precharge_n, o_dac_en, o_busy}, {7'h7f, 1'b0, 2'b00, 1'b1}); end
        exp_v = sb.pop_front();
        checks++; if ({o_ch, o_result, o_nodetect} !== exp_v) begin errors++; $display("FAIL lin_result: got %0h expected %0h", {o_ch, o_result, o_nodetect}, exp_v); end
        @(negedge clk);
        checks++; if ({o_busy, o_valid} !== 2'b00) begin errors++; $display("FAIL lin_idle: got %b expected 00", {o_busy, o_valid}); end
    endtask

    task automatic test_sar_two_ch;
        bit ok;
        int cnt;
        t_val[0] = 100; t_val[1] = 17;
        sb.push_back({1'b0, 7'd100, 1'b0});
        sb.push_back({1'b1, 7'd17, 1'b0});
        do_start(1, 2'b11);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_dac_en !== (2'b01 << k)) begin errors++; $display("FAIL sar_en_ch%0d: got %b expected %b", k, o_dac_en, 2'b01 << k); end
            wait_valid(500, ok, cnt);
            checks++; if (!ok || cnt !== 112) begin errors++; $display("FAIL sar_cycles_ch%0d: got %0d expected 112", k, cnt); end
            exp_v = sb.pop_front();
            checks++; if ({o_ch, o_result, o_nodetect} !== exp_v) begin errors++; $display("FAIL sar_result_ch%0d: got %0h expected %0h", k, {o_ch, o_result, o_nodetect}, exp_v); end
            @(negedge clk);
        end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL sar_busy_drop: got %b expected 0", o_busy); end
    endtask

    task automatic test_sar_sweep;
        bit ok;
        int cnt;
        pc_clr = 1;
        @(negedge clk);
        pc_clr = 0;
        sweep_en = 1;
        sb.push_back({1'b0, 7'd41, 1'b0});
        do_start(1, 2'b01);
        wait_valid(500, ok, cnt);
        exp_v = sb.pop_front();
        checks++; if (!ok || {o_ch, o_result, o_nodetect} !== exp_v) begin errors++; $display("FAIL sweep_result: got %0h expected %0h", {o_ch, o_result, o_nodetect}, exp_v); end
        @(negedge clk);
        sweep_en = 0;
    endtask

    task automatic test_stuck;
        bit ok;
        int cnt;
        for (int v = 0; v < 2; v++) begin
            stuck_en = 1; stuck_val = v[0];
            sb.push_back({1'b0, 7'd0, 1'b1});
            do_start(0, 2'b01);
            wait_valid(5000, ok, cnt);
            exp_v = sb.pop_front();
            checks++; if (!ok || {o_ch, o_result, o_nodetect} !== exp_v) begin errors++; $display("FAIL stuck%0d_result: got %0h expected %0h", v, {o_ch, o_result, o_nodetect}, exp_v); end
            @(negedge clk);
            stuck_en = 0;
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int cnt;
        i_ready = 0;
        t_val[1] = 77;
        sb.push_back({1'b1, 7'd77, 1'b0});
        do_start(1, 2'b10);
        wait_valid(500, ok, cnt);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got valid=0 expected valid=1"); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin i_start = 1; i_mode = 0; i_ch_mask = 2'b11; end
            else i_start = 0;
            @(negedge clk);
            checks++;
            if ({o_valid, o_busy, o_dac_en, o_dac_data, o_precharge_n, o_ch, o_result, o_nodetect} !==
                {1'b1, 1'b1, 2'b00, 7'h7f, 1'b0, sb[0]}) begin
                errors++; $display("FAIL bp_hold_%0d: got %0h expected %0h", i,
                    {o_valid, o_busy, o_dac_en, o_dac_data, o_precharge_n, o_ch, o_result, o_nodetect},
                    {1'b1, 1'b1, 2'b00, 7'h7f, 1'b0, sb[0]});
            end
        end
        i_start = 0;
        i_ready = 1;
        #1;
        exp_v = sb.pop_front();
        checks++; if ({o_ch, o_result, o_nodetect} !== exp_v) begin errors++; $display("FAIL bp_result: got %0h expected %0h", {o_ch, o_result, o_nodetect}, exp_v); end
        repeat (5) begin
            @(negedge clk);
            checks++; if ({o_busy, o_valid} !== 2'b00) begin errors++; $display("FAIL bp_no_restart: got %b expected 00", {o_busy, o_valid}); end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int cnt;
        t_val[0] = 90;
        do_start(1, 2'b01);
        repeat (30) @(negedge clk);
        #2 reset = 1;
        #1;
        checks++; if ({o_dac_data, o_dac_en, o_precharge_n, o_busy, o_valid} !== {7'h7f, 2'b00, 3'b000}) begin errors++; $display("FAIL rst_mid_pins: got %0h expected %0h", {o_dac_data, o_dac_en, o_precharge_n, o_busy, o_valid}, {7'h7f, 2'b00, 3'b000}); end
        checks++; if ({o_ch, o_result, o_nodetect} !== 9'h0) begin errors++; $display("FAIL rst_mid_res: got %0h expected 0", {o_ch, o_result, o_nodetect}); end
        @(negedge clk);
        reset = 0;
        t_val[0] = 64;
        i_mode = 1; i_ch_mask = 2'b01; i_start = 1;
        @(negedge clk);
        i_start = 0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_restart_busy: got %b expected 1", o_busy); end
        sb.push_back({1'b0, 7'd64, 1'b0});
        wait_valid(500, ok, cnt);
        exp_v = sb.pop_front();
        checks++; if (!ok || {o_ch, o_result, o_nodetect} !== exp_v) begin errors++; $display("FAIL rst_restart_result: got %0h expected %0h", {o_ch, o_result, o_nodetect}, exp_v); end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mask_zero();
        test_linear();
        test_sar_two_ch();
        test_sar_sweep();
        test_stuck();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tempsens_scan_ctrl.md
TEMPSENS_SCAN_CTRL -- requirements
Module: tempsens_scan_ctrl

Interface
REQ-001 SHALL have parameter N_VDAC, default 7: DAC code width; VMAX = all ones, VMIN = 0.
REQ-002 SHALL have parameter N_CH, default 2: number of delay-sensor channels, minimum 1.
REQ-003 SHALL have parameter N_AVG_LOG2, default 2: 2**N_AVG_LOG2 conversions are averaged per channel.
REQ-004 SHALL derive CH_W = max(1, clog2(N_CH)).
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_start, input, 1: starts a scan; sampled only in IDLE.
REQ-008 SHALL have port i_mode, input, 1: 0 selects linear sweep, 1 selects SAR; latched at start.
REQ-009 SHALL have port i_ch_mask, input, N_CH: channels to scan; latched at start.
REQ-010 SHALL have port i_tempdelay, input, N_CH: per-channel delay-cell outputs.
REQ-011 SHALL have port o_dac_data, output, N_VDAC: shared sensor DAC code.
REQ-012 SHALL have port o_dac_en, output, N_CH: one-hot enable of the active channel.
REQ-013 SHALL have port o_precharge_n, output, 1: 0 = precharge, 1 = measure.
REQ-014 SHALL have port o_busy, output, 1: high from the accepted start until the last result is accepted.
REQ-015 SHALL have ports o_valid (output, 1) and i_ready (input, 1): result handshake.
REQ-016 SHALL have ports o_result (output, N_VDAC), o_ch (output, CH_W) and o_nodetect (output, 1).

Function
REQ-017 SHALL run one trial as 4 cycles: PRECHARGE (dac=VMAX, pre_n=0), TRANSITION (dac=VMIN, pre_n=1), MEASURE (dac=trial, pre_n=1), EVALUATE (dac=trial, pre_n=1).
REQ-018 SHALL take hit = i_tempdelay[ch] as sampled on the clock edge that ends EVALUATE.
REQ-019 In linear mode, SHALL step trial from VMAX down to 0, with the previous hit initialised to 1.
REQ-020 In linear mode, SHALL end the conversion at the first trial with a 0->1 hit edge; conversion code = that trial, nodetect = 0.
REQ-021 In linear mode, if trial 0 completes with no edge, SHALL set conversion code = 0 and nodetect = 1.
REQ-022 In SAR mode, SHALL run N_VDAC trials, MSB first: trial = code | bit; the bit is kept if hit = 1.
REQ-023 In SAR mode, SHALL set nodetect = 1 if no trial hit.
REQ-024 SHALL run 2**N_AVG_LOG2 conversions per channel, accumulating codes in N_VDAC+N_AVG_LOG2 bits with no overflow.
REQ-025 SHALL set o_result = accumulator >> N_AVG_LOG2 (truncation) and o_nodetect = OR of the conversion nodetects.
REQ-026 SHALL start the next conversion's PRECHARGE on the cycle after the previous conversion's final EVALUATE.
REQ-027 SHALL scan set mask bits in ascending index order, skipping clear bits.
REQ-028 SHALL drive o_dac_en high only for the active channel during its trials.
REQ-029 SHALL enter OUTPUT on the cycle after a channel's last EVALUATE: o_valid = 1, dac_en = 0, dac = VMAX, pre_n = 0.
REQ-030 SHALL hold o_result, o_ch and o_nodetect stable while o_valid = 1 and i_ready = 0.
REQ-031 On o_valid & i_ready, SHALL go to the next masked channel's PRECHARGE; if none remain, SHALL go to IDLE and drop o_busy.
REQ-032 SHALL ignore i_start while busy.
REQ-033 SHALL ignore i_start when i_ch_mask = 0, keeping o_busy at 0.
REQ-034 SHALL begin the first PRECHARGE on the cycle after the start is accepted.
REQ-035 In IDLE, SHALL drive dac_en = 0, dac = VMAX and pre_n = 0.

Reset
REQ-036 On reset assertion, SHALL immediately (without a clock edge) force: state IDLE, o_dac_data = VMAX, o_dac_en = 0, o_precharge_n = 0, o_busy = 0, o_valid = 0, o_result = 0, o_ch = 0, o_nodetect = 0, accumulator = 0.
REQ-037 Reset mid-trial or mid-handshake SHALL discard all partial results.
REQ-038 After reset, a start SHALL be accepted on the first clock edge after reset deassertion.

Verification (N_VDAC=7, N_CH=2, N_AVG_LOG2=2; sensor model: hit = dac <= T)
REQ-039 SHALL cover: linear, mask=01, T=50 -> each conversion is 78 trials (312 cycles); o_result=50, o_ch=0, o_nodetect=0.
REQ-040 SHALL cover: SAR, mask=11, T0=100, T1=17 -> each conversion takes 28 cycles; results ch0=100, then ch1=17.
REQ-041 SHALL cover: SAR, T stepping 40, 41, 42, 43 across the four conversions -> accumulator 166, o_result=41.
REQ-042 SHALL cover: linear with hit stuck at 0, and separately with hit stuck at 1 -> o_result=0, o_nodetect=1 in both cases.
REQ-043 SHALL cover: i_ready low for 20 cycles with a second i_start pulse -> outputs stable, dac_en=0, no restart; completes normally after i_ready rises.
REQ-044 SHALL cover: reset asserted mid-SAR between clock edges -> all REQ-036 values appear immediately; next scan with T=64 -> o_result=64.
